// File: rtl/PixelSensorConfig.sv
// Sensor-wide geometry constants shared by the readout path.
// Latency: none (constants only).
// Backpressure: none (constants only).
package PixelSensorConfig;
    parameter int PIXEL_ARRAY_WIDTH = 8;  // pixels per row
    parameter int OUTPUT_BUS_WIDTH  = 2;  // pixels per output beat
    parameter int PIXEL_BITS        = 4;  // bits per pixel
endpackage

// File: rtl/row_output_serializer.sv
// Two-slot ping-pong row store; streams each captured row out as BEATS narrow beats.
// Latency: load accepted at edge n -> beat 0 valid after edge n (if the read slot was empty).
// Backpressure: valid/ready on the output; load_ready low while both slots are full, a load then is dropped and sets sticky overflow.
//
// Ports:
//   clk, reset (async, active-low), clear (sync flush)
//   load / data_in / load_ready : full-row capture side
//   data_out / out_valid / out_ready / out_first / out_last : beat stream
//   overflow : sticky, set by a load while load_ready is low
module row_output_serializer #(
    parameter int PIXEL_ARRAY_WIDTH = PixelSensorConfig::PIXEL_ARRAY_WIDTH,
    parameter int OUTPUT_BUS_WIDTH  = PixelSensorConfig::OUTPUT_BUS_WIDTH,
    parameter int PIXEL_BITS        = PixelSensorConfig::PIXEL_BITS,
    parameter bit REVERSE_ORDER     = 1'b0
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         clear,
    input  logic                                         load,
    input  logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] data_in,
    output logic                                         load_ready,
    output logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  data_out,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic                                         out_first,
    output logic                                         out_last,
    output logic                                         overflow
);

    localparam int BEATS    = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);

    typedef logic [PIXEL_ARRAY_WIDTH-1:0][PIXEL_BITS-1:0] row_t;
    typedef logic [OUTPUT_BUS_WIDTH-1:0][PIXEL_BITS-1:0]  beat_t;

    // Geometry sanity: a row must split into whole beats.
    if (OUTPUT_BUS_WIDTH < 1 || (PIXEL_ARRAY_WIDTH % OUTPUT_BUS_WIDTH) != 0) begin : g_bad_geometry
        $error("row_output_serializer: PIXEL_ARRAY_WIDTH must be a multiple of OUTPUT_BUS_WIDTH");
    end

    row_t                slot_dat [2];
    logic [1:0]          slot_full;
    logic [1:0]          slot_full_nxt;
    logic                wr_sel;
    logic                rd_sel;
    logic [CNT_BITS-1:0] beat;
    logic [CNT_BITS-1:0] grp;
    row_t                rd_row;
    beat_t               beat_dat;
    logic                beat_is_last;
    logic                load_acc;
    logic                load_rej;
    logic                xfer;
    logic                xfer_last;

    // ------------------------------------------------------------------
    // Handshake decode. Everything here derives from registered state plus
    // the current-cycle strobes, so load_ready never depends on out_ready.
    // ------------------------------------------------------------------
    assign load_ready   = ~(&slot_full);
    assign out_valid    = slot_full[rd_sel];
    assign beat_is_last = (beat == LAST_BEAT);
    assign load_acc     = load && load_ready && !clear;
    assign load_rej     = load && !load_ready;
    assign xfer         = out_valid && out_ready;
    assign xfer_last    = xfer && beat_is_last;

    assign out_first = out_valid && (beat == '0);
    assign out_last  = out_valid && beat_is_last;

    // Reverse mode walks groups from the top; pixel order within a beat is kept.
    assign grp    = REVERSE_ORDER ? (LAST_BEAT - beat) : beat;
    assign rd_row = slot_dat[rd_sel];

    // Beat selection is a mux over the stored row, never a shift, so the slot
    // contents stay put until the slot is released on the last transfer.
    always_comb begin
        beat_dat = '0;
        for (int g = 0; g < BEATS; g++) begin
            if (grp == CNT_BITS'(g)) begin
                beat_dat = rd_row[g*OUTPUT_BUS_WIDTH +: OUTPUT_BUS_WIDTH];
            end
        end
    end

    // Bus idles at zero so stale rows never appear on the pads.
    assign data_out = out_valid ? beat_dat : '0;

    // Slot occupancy. The write slot is always empty whenever load_ready is
    // high (slots fill and drain in strict alternation), so a release and a
    // capture in the same cycle always touch different slots.
    always_comb begin
        slot_full_nxt = slot_full;
        if (xfer_last) begin
            slot_full_nxt[rd_sel] = 1'b0;
        end
        if (load_acc) begin
            slot_full_nxt[wr_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_full <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            beat      <= '0;
            overflow  <= 1'b0;
        end else if (clear) begin
            // Flush wins over any load or transfer in the same cycle.
            slot_full <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            beat      <= '0;
            overflow  <= 1'b0;
        end else begin
            slot_full <= slot_full_nxt;
            if (load_acc) begin
                wr_sel <= ~wr_sel;
            end
            if (load_rej) begin
                overflow <= 1'b1;
            end
            if (xfer) begin
                if (beat_is_last) begin
                    beat   <= '0;
                    rd_sel <= ~rd_sel;
                end else begin
                    beat <= beat + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Row storage: written only on an accepted load, into the write slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < 2; s++) begin
                slot_dat[s] <= '0;
            end
        end else if (load_acc) begin
            slot_dat[wr_sel] <= data_in;
        end
    end

endmodule
